// File: rtl/lpc_pkg.sv
// ---------------------------------------------------------------------------
// lpc_pkg
// Shared definitions for the LPC I/O-cycle target: the FSM state encoding,
// the LPC cycle-type nibbles the target claims, SYNC codes and the START
// nibble.
// ---------------------------------------------------------------------------
package lpc_pkg;

  // FSM states. LPC_SWAIT is only reachable when LPC_SYNC_WAIT_EN is defined.
  typedef enum logic [3:0] {
    LPC_IDLE    = 4'd0,
    LPC_CYCTYPE = 4'd1,
    LPC_ADDR    = 4'd2,
    LPC_WDATA   = 4'd3,
    LPC_HTAR    = 4'd4,
    LPC_SWAIT   = 4'd5,
    LPC_SYNC    = 4'd6,
    LPC_RDATA   = 4'd7,
    LPC_PTAR    = 4'd8
  } lpc_state_e;

  localparam logic [3:0] LPC_START      = 4'h0;
  localparam logic [3:0] LPC_CT_IO_RD   = 4'h0;
  localparam logic [3:0] LPC_CT_IO_WR   = 4'h2;
  localparam logic [3:0] LPC_SYNC_READY = 4'h0;
  localparam logic [3:0] LPC_SYNC_SHORT = 4'h5;
  localparam logic [3:0] LPC_LAD_IDLE   = 4'hF;

endpackage

// File: rtl/lpc_io_target.sv
// ---------------------------------------------------------------------------
// lpc_io_target
// LPC I/O-cycle target. Decodes host I/O read/write cycles on LAD/LFRAME#
// that fall inside a 2**WIN_BITS byte window at BASE_ADDR and turns them into
// byte-wide register-file strobes; read data is returned on LAD.
//
// Optional feature: define LPC_SYNC_WAIT_EN to insert one short-wait SYNC
// (LAD=5) before the ready SYNC; all later phases shift by one clock.
//
// Ports
//   LpcClock  in   LPC clock, all logic on the rising edge
//   PciReset  in   asynchronous active-high reset
//   LpcFrame  in   LFRAME#, active low
//   LadIn     in   LAD[3:0] as sampled from the pins
//   LadOut    out  LAD value driven by the target (F when not driving)
//   LadOe     out  LAD output enable
//   RdData    in   register-file read data for the current Addr
//   Addr      out  register offset {3'b0, addr[4:0]}, held between cycles
//   Wr        out  one-cycle write strobe, only ever in the ready SYNC cycle
//   DataWr    out  write data, valid while Wr is high
//   DbgState  out  current FSM state
//
// Handshake: the target has no valid/ready pair; the host owns LAD except in
// SYNC/RDATA/PTAR. A cycle is "claimed" only when the cycle type is an I/O
// read/write and the address hits the window; otherwise LAD is never driven.
// All LAD outputs are registered: a value the host samples at edge N was
// launched at edge N-1.
// ---------------------------------------------------------------------------
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0800,
  parameter int          WIN_BITS  = 5
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LpcFrame,
  input  logic [3:0] LadIn,
  output logic [3:0] LadOut,
  output logic       LadOe,
  input  logic [7:0] RdData,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWr,
  output lpc_state_e DbgState
);

  localparam logic [15:0] WIN_MASK = 16'((32'd1 << WIN_BITS) - 32'd1);

  lpc_state_e  state_q, state_n;
  logic [1:0]  cnt_q, cnt_n;
  logic [11:0] addr_sh_q, addr_sh_n;
  logic        is_wr_q, is_wr_n;
  logic [7:0]  data_q, data_n;
  logic [7:0]  rd_byte_q, rd_byte_n;
  logic [7:0]  addr_q, addr_n;
  logic [3:0]  lad_out_q, lad_out_n;
  logic        lad_oe_q, lad_oe_n;
  logic        wr_q, wr_n;

  // Full address as seen on the last ADDR edge (three shifted nibbles plus
  // the nibble on the pins right now).
  logic [15:0] addr_full;
  logic        addr_hit;

  assign addr_full = {addr_sh_q, LadIn};
  assign addr_hit  = ((addr_full ^ BASE_ADDR) & ~WIN_MASK) == 16'h0000;

  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) begin
      state_q   <= LPC_IDLE;
      cnt_q     <= 2'd0;
      addr_sh_q <= 12'h000;
      is_wr_q   <= 1'b0;
      data_q    <= 8'h00;
      rd_byte_q <= 8'h00;
      addr_q    <= 8'h00;
      lad_out_q <= LPC_LAD_IDLE;
      lad_oe_q  <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      addr_sh_q <= addr_sh_n;
      is_wr_q   <= is_wr_n;
      data_q    <= data_n;
      rd_byte_q <= rd_byte_n;
      addr_q    <= addr_n;
      lad_out_q <= lad_out_n;
      lad_oe_q  <= lad_oe_n;
      wr_q      <= wr_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    addr_sh_n = addr_sh_q;
    is_wr_n   = is_wr_q;
    data_n    = data_q;
    rd_byte_n = rd_byte_q;
    addr_n    = addr_q;
    // Outputs default to "not driving": this alone implements the abort
    // rule, since any LFRAME# low edge lands in the first branch below.
    lad_out_n = LPC_LAD_IDLE;
    lad_oe_n  = 1'b0;
    wr_n      = 1'b0;

    if (!LpcFrame) begin
      // START detection (also abort from any state). While LFRAME# stays
      // low the most recent nibble decides whether we are armed.
      cnt_n   = 2'd0;
      state_n = (LadIn == LPC_START) ? LPC_CYCTYPE : LPC_IDLE;
    end else begin
      case (state_q)
        LPC_IDLE: begin
          state_n = LPC_IDLE;
        end

        LPC_CYCTYPE: begin
          cnt_n = 2'd0;
          if (LadIn == LPC_CT_IO_RD) begin
            is_wr_n = 1'b0;
            state_n = LPC_ADDR;
          end else if (LadIn == LPC_CT_IO_WR) begin
            is_wr_n = 1'b1;
            state_n = LPC_ADDR;
          end else begin
            state_n = LPC_IDLE;
          end
        end

        LPC_ADDR: begin
          addr_sh_n = {addr_sh_q[7:0], LadIn};
          cnt_n     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_n = 2'd0;
            if (addr_hit) begin
              // Addr only moves on a claimed cycle so it holds otherwise.
              addr_n  = addr_full[7:0] & WIN_MASK[7:0];
              state_n = is_wr_q ? LPC_WDATA : LPC_HTAR;
            end else begin
              state_n = LPC_IDLE;
            end
          end
        end

        LPC_WDATA: begin
          if (cnt_q == 2'd0) begin
            data_n[3:0] = LadIn;
            cnt_n       = 2'd1;
          end else begin
            data_n[7:4] = LadIn;
            cnt_n       = 2'd0;
            state_n     = LPC_HTAR;
          end
        end

        LPC_HTAR: begin
          if (cnt_q == 2'd0) begin
            cnt_n = 2'd1;
          end else begin
            cnt_n    = 2'd0;
            lad_oe_n = 1'b1;
`ifdef LPC_SYNC_WAIT_EN
            state_n   = LPC_SWAIT;
            lad_out_n = LPC_SYNC_SHORT;
`else
            state_n   = LPC_SYNC;
            lad_out_n = LPC_SYNC_READY;
            wr_n      = is_wr_q;
`endif
          end
        end

        LPC_SWAIT: begin
          state_n   = LPC_SYNC;
          lad_oe_n  = 1'b1;
          lad_out_n = LPC_SYNC_READY;
          wr_n      = is_wr_q;
        end

        LPC_SYNC: begin
          cnt_n    = 2'd0;
          lad_oe_n = 1'b1;
          if (is_wr_q) begin
            state_n   = LPC_PTAR;
            lad_out_n = LPC_LAD_IDLE;
          end else begin
            // Capture at the end of SYNC; low nibble goes out immediately.
            rd_byte_n = RdData;
            lad_out_n = RdData[3:0];
            state_n   = LPC_RDATA;
          end
        end

        LPC_RDATA: begin
          lad_oe_n = 1'b1;
          if (cnt_q == 2'd0) begin
            cnt_n     = 2'd1;
            lad_out_n = rd_byte_q[7:4];
          end else begin
            cnt_n     = 2'd0;
            lad_out_n = LPC_LAD_IDLE;
            state_n   = LPC_PTAR;
          end
        end

        LPC_PTAR: begin
          // First PTAR cycle (F, driven) was launched on entry; here we
          // launch the released second cycle, then return to IDLE.
          if (cnt_q == 2'd0) begin
            cnt_n = 2'd1;
          end else begin
            cnt_n   = 2'd0;
            state_n = LPC_IDLE;
          end
        end

        default: begin
          cnt_n   = 2'd0;
          state_n = LPC_IDLE;
        end
      endcase
    end
  end

  assign LadOut   = lad_out_q;
  assign LadOe    = lad_oe_q;
  assign Addr     = addr_q;
  assign Wr       = wr_q;
  assign DataWr   = data_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_lpc_io_target.sv
// ---------------------------------------------------------------------------
// tb_lpc_io_target
// Directed bench for lpc_io_target. The host side is driven on the falling
// edge; outputs are observed on the same falling edge before new inputs are
// applied, so obs_*[e] is what the host samples at rising edge e (edge 0 is
// the CYCTYPE edge).
// ---------------------------------------------------------------------------
module tb_lpc_io_target;
  import lpc_pkg::*;

`ifdef LPC_SYNC_WAIT_EN
  localparam int SW = 1;
`else
  localparam int SW = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame;
  logic [3:0] lad_in;
  logic [3:0] lad_out;
  logic       lad_oe;
  logic [7:0] rd_data;
  logic [7:0] addr;
  logic       wr;
  logic [7:0] data_wr;
  lpc_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic       obs_oe  [16];
  logic [3:0] obs_lad [16];
  logic       obs_wr  [16];
  logic [7:0] obs_addr[16];
  logic [7:0] obs_dw  [16];
  lpc_state_e obs_st  [16];

  logic       rst_oe;
  logic [3:0] rst_lad;
  logic       rst_wr;
  logic [7:0] rst_addr;
  lpc_state_e rst_st;

  lpc_io_target #(.BASE_ADDR(16'h0800), .WIN_BITS(5)) dut (
    .LpcClock(clk),
    .PciReset(rst),
    .LpcFrame(frame),
    .LadIn(lad_in),
    .LadOut(lad_out),
    .LadOe(lad_oe),
    .RdData(rd_data),
    .Addr(addr),
    .Wr(wr),
    .DataWr(data_wr),
    .DbgState(dbg_state)
  );

  // ---------------- clock ----------------
  always #15 clk = ~clk;

  // ---------------- driver ----------------
  function automatic logic [3:0] host_nib(input int e, input logic [3:0] ct,
                                          input logic [15:0] a, input logic [7:0] d);
    logic [3:0] n;
    n = 4'hF;
    case (e)
      0: n = ct;
      1: n = a[15:12];
      2: n = a[11:8];
      3: n = a[7:4];
      4: n = a[3:0];
      5: n = (ct == LPC_CT_IO_WR) ? d[3:0] : 4'hF;
      6: n = (ct == LPC_CT_IO_WR) ? d[7:4] : 4'hF;
      default: n = 4'hF;
    endcase
    return n;
  endfunction

  // One host cycle: START, then n edges starting at CYCTYPE. abort_at pulls
  // LFRAME# low (LAD=F) on that edge; rst_at pulses PciReset mid-cycle.
  task automatic run_io(input logic [3:0] ct, input logic [15:0] a,
                        input logic [7:0] d, input int n,
                        input int abort_at, input int rst_at);
    @(negedge clk);
    frame  = 1'b0;
    lad_in = LPC_START;
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      obs_oe[e]   = lad_oe;
      obs_lad[e]  = lad_out;
      obs_wr[e]   = wr;
      obs_addr[e] = addr;
      obs_dw[e]   = data_wr;
      obs_st[e]   = dbg_state;
      if (e == rst_at + 1) rst = 1'b0;
      if (e == rst_at) begin
        rst = 1'b1;
        #1;
        rst_oe   = lad_oe;
        rst_lad  = lad_out;
        rst_wr   = wr;
        rst_addr = addr;
        rst_st   = dbg_state;
      end
      if (e == abort_at) begin
        frame  = 1'b0;
        lad_in = 4'hF;
      end else begin
        frame  = 1'b1;
        lad_in = host_nib(e, ct, a, d);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; frame = 1'b1; lad_in = 4'hF; rd_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (lad_out !== 4'hF) begin errors++; $display("FAIL reset_lad_out got %h want F", lad_out); end
    checks++; if (lad_oe !== 1'b0) begin errors++; $display("FAIL reset_lad_oe got %b want 0", lad_oe); end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", addr); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", wr); end
    checks++; if (data_wr !== 8'h00) begin errors++; $display("FAIL reset_data_wr got %h want 00", data_wr); end
    checks++; if (dbg_state !== LPC_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write(input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] exp_addr, input int n);
    logic eo; logic [3:0] el; logic ew; int s;
    s = 9 + SW;
    run_io(LPC_CT_IO_WR, a, d, n, -1, -1);
    for (int e = 0; e < n; e++) begin
      eo = (e >= 9 && e <= s + 1);
      el = (e == s) ? 4'h0 : ((SW == 1 && e == 9) ? 4'h5 : 4'hF);
      ew = (e == s);
      checks++;
      if (obs_oe[e] !== eo || obs_lad[e] !== el || obs_wr[e] !== ew) begin
        errors++;
        $display("FAIL write_edge%0d got oe=%b lad=%h wr=%b want oe=%b lad=%h wr=%b",
                 e, obs_oe[e], obs_lad[e], obs_wr[e], eo, el, ew);
      end
    end
    checks++; if (obs_addr[s] !== exp_addr) begin errors++; $display("FAIL write_addr got %h want %h", obs_addr[s], exp_addr); end
    checks++; if (obs_dw[s] !== d) begin errors++; $display("FAIL write_data got %h want %h", obs_dw[s], d); end
  endtask

  task automatic test_read(input logic [15:0] a, input logic [7:0] rd,
                           input logic [7:0] exp_addr, input int n);
    logic eo; logic [3:0] el; int s;
    s = 7 + SW;
    rd_data = rd;
    run_io(LPC_CT_IO_RD, a, 8'h00, n, -1, -1);
    for (int e = 0; e < n; e++) begin
      eo = (e >= 7 && e <= s + 3);
      if (e == s)                  el = 4'h0;
      else if (e == s + 1)         el = rd[3:0];
      else if (e == s + 2)         el = rd[7:4];
      else if (SW == 1 && e == 7)  el = 4'h5;
      else                         el = 4'hF;
      checks++;
      if (obs_oe[e] !== eo || obs_lad[e] !== el || obs_wr[e] !== 1'b0) begin
        errors++;
        $display("FAIL read_edge%0d got oe=%b lad=%h wr=%b want oe=%b lad=%h wr=0",
                 e, obs_oe[e], obs_lad[e], obs_wr[e], eo, el);
      end
    end
    checks++; if (obs_addr[s] !== exp_addr) begin errors++; $display("FAIL read_addr got %h want %h", obs_addr[s], exp_addr); end
  endtask

  task automatic test_miss(input logic [7:0] prev_addr);
    run_io(LPC_CT_IO_RD, 16'h0900, 8'h00, 10, -1, -1);
    for (int e = 0; e < 10; e++) begin
      checks++;
      if (obs_oe[e] !== 1'b0 || obs_wr[e] !== 1'b0) begin
        errors++; $display("FAIL miss_edge%0d got oe=%b wr=%b want oe=0 wr=0", e, obs_oe[e], obs_wr[e]);
      end
    end
    checks++; if (obs_st[4] !== LPC_ADDR) begin errors++; $display("FAIL miss_state4 got %0d want ADDR", obs_st[4]); end
    checks++; if (obs_st[5] !== LPC_IDLE) begin errors++; $display("FAIL miss_state5 got %0d want IDLE", obs_st[5]); end
    checks++; if (obs_addr[9] !== prev_addr) begin errors++; $display("FAIL miss_addr_hold got %h want %h", obs_addr[9], prev_addr); end
  endtask

  task automatic test_bad_cyctype();
    run_io(4'h4, 16'h0804, 8'h00, 8, -1, -1);
    checks++; if (obs_st[1] !== LPC_IDLE) begin errors++; $display("FAIL badct_state got %0d want IDLE", obs_st[1]); end
    for (int e = 0; e < 8; e++) begin
      checks++;
      if (obs_oe[e] !== 1'b0 || obs_wr[e] !== 1'b0) begin
        errors++; $display("FAIL badct_edge%0d got oe=%b wr=%b want oe=0 wr=0", e, obs_oe[e], obs_wr[e]);
      end
    end
  endtask

  task automatic test_abort();
    run_io(LPC_CT_IO_WR, 16'h0804, 8'h66, 14, 6, -1);
    for (int e = 0; e < 14; e++) begin
      checks++;
      if (obs_oe[e] !== 1'b0 || obs_wr[e] !== 1'b0) begin
        errors++; $display("FAIL abort_edge%0d got oe=%b wr=%b want oe=0 wr=0", e, obs_oe[e], obs_wr[e]);
      end
    end
    checks++; if (obs_st[7] !== LPC_IDLE) begin errors++; $display("FAIL abort_state got %0d want IDLE", obs_st[7]); end
    test_read(16'h081F, 8'hC3, 8'h1F, 14);
  endtask

  task automatic test_reset_mid();
    int ra;
    ra = 9 + SW;
    rd_data = 8'h55;
    run_io(LPC_CT_IO_RD, 16'h0801, 8'h00, 14, -1, ra);
    checks++; if (obs_oe[ra] !== 1'b1 || obs_lad[ra] !== 4'h5) begin errors++; $display("FAIL rstmid_pre got oe=%b lad=%h want oe=1 lad=5", obs_oe[ra], obs_lad[ra]); end
    checks++; if (rst_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b want 0", rst_oe); end
    checks++; if (rst_lad !== 4'hF) begin errors++; $display("FAIL rstmid_lad got %h want F", rst_lad); end
    checks++; if (rst_wr !== 1'b0 || rst_addr !== 8'h00) begin errors++; $display("FAIL rstmid_wr_addr got wr=%b addr=%h want wr=0 addr=00", rst_wr, rst_addr); end
    checks++; if (rst_st !== LPC_IDLE) begin errors++; $display("FAIL rstmid_state got %0d want IDLE", rst_st); end
    test_read(16'h0802, 8'h9A, 8'h02, 14);
  endtask

  task automatic test_back_to_back();
    // Write ends with PTAR cycle 2; the read's START is the very next edge.
    test_write(16'h0810, 8'h7E, 8'h10, 12 + SW);
    test_read(16'h0803, 8'h81, 8'h03, 14);
  endtask

`ifdef LPC_SYNC_WAIT_EN
  task automatic test_sync_wait();
    test_write(16'h0804, 8'h3C, 8'h04, 14);
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write(16'h0804, 8'hA5, 8'h04, 14);
    test_read(16'h0801, 8'h55, 8'h01, 14);
    test_miss(8'h01);
    test_bad_cyctype();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef LPC_SYNC_WAIT_EN
    test_sync_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
